// File: rtl/tlul_pkg.sv
// Shared TL-UL types and constants for the SRAM host arbiter slice.
package tlul_pkg;

   localparam int NumSramHosts = 2;

   typedef logic sram_host_idx_t;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef struct packed {
      logic        a_valid;
      tl_a_op_e    a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic [15:0] a_user;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic [15:0] d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous ring-buffer FIFO with optional empty pass-through and an
// occupancy output. Writes while full are dropped; callers gate on depth_o.
module prim_fifo_sync #(
   parameter int unsigned Width = 16,
   parameter int unsigned Depth = 4,
   parameter bit          Pass  = 1'b1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       wvalid_i,
   input  logic [Width-1:0]           wdata_i,
   output logic                       rvalid_o,
   input  logic                       rready_i,
   output logic [Width-1:0]           rdata_o,
   output logic [$clog2(Depth+1)-1:0] depth_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [CntW-1:0]  cnt_q;
   logic             empty, full, pass_thru, do_write, do_pop;

   assign empty     = (cnt_q == '0);
   assign full      = (cnt_q == CntW'(Depth));
   assign pass_thru = Pass && empty && wvalid_i;
   assign rvalid_o  = !empty || pass_thru;
   assign rdata_o   = empty ? wdata_i : mem_q[rptr_q];
   assign do_pop    = rready_i && !empty;
   assign do_write  = wvalid_i && !full && !(pass_thru && rready_i);
   assign depth_o   = cnt_q;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // Storage write; contents need no reset because cnt_q qualifies them.
   always_ff @(posedge clk_i) begin
      if (do_write) mem_q[wptr_q] <= wdata_i;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_write) wptr_q <= next_ptr(wptr_q);
         if (do_pop)   rptr_q <= next_ptr(rptr_q);
         case ({do_write, do_pop})
            2'b10:   cnt_q <= cnt_q + CntW'(1);
            2'b01:   cnt_q <= cnt_q - CntW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/tlul_sram_arb.sv
// Two-host round-robin TL-UL arbiter in front of a shared SRAM path.
// Handshake: a transfer happens on a channel exactly when valid and ready
// are both 1 at a rising clock edge; valid never waits on ready.
// An in-order ID FIFO remembers which host owns each outstanding response.
module tlul_sram_arb
   import tlul_pkg::*;
#(
   parameter int unsigned Outstanding = 2,
   parameter bit          LockOnStall = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  tl_h2d_t                 tl_h_i [NumSramHosts],
   output tl_d2h_t                 tl_h_o [NumSramHosts],
   input  logic [NumSramHosts-1:0] error_h_i,
   output tl_h2d_t                 tl_dev_o,
   input  tl_d2h_t                 tl_dev_i,
   output logic                    error_o
);

   localparam int unsigned CntW = $clog2(Outstanding + 1);

   sram_host_idx_t  prio_q, grant_q, arb_grant, grant, id_head;
   logic            lock_q;
   logic [CntW-1:0] id_depth;
   logic            id_full, id_nonempty;
   logic            a_allow, dev_a_valid, a_ack, dev_d_ready, d_ack;

   // Round-robin pick: a lone requester wins, a tie goes to prio_q.
   always_comb begin
      arb_grant = 1'b0;
      if (tl_h_i[0].a_valid && tl_h_i[1].a_valid) arb_grant = prio_q;
      else if (tl_h_i[1].a_valid)                 arb_grant = 1'b1;
   end

   assign grant       = lock_q ? grant_q : arb_grant;
   assign id_full     = (id_depth == CntW'(Outstanding));
   // Outputs stay quiet throughout reset, not just after the first edge.
   assign a_allow     = rst_ni & ~id_full;
   assign dev_a_valid = tl_h_i[grant].a_valid & a_allow;
   assign a_ack       = dev_a_valid & tl_dev_i.a_ready;
   assign dev_d_ready = rst_ni & id_nonempty & tl_h_i[id_head].d_ready;
   assign d_ack       = tl_dev_i.d_valid & dev_d_ready;
   assign error_o     = rst_ni & error_h_i[grant] & tl_h_i[grant].a_valid;

   // Request mux downstream and response demux back to the head-of-FIFO host.
   always_comb begin
      tl_dev_o         = tl_h_i[grant];
      tl_dev_o.a_valid = dev_a_valid;
      tl_dev_o.d_ready = dev_d_ready;
      for (int h = 0; h < NumSramHosts; h++) begin
         tl_h_o[h]         = tl_dev_i;
         tl_h_o[h].a_ready = (grant == sram_host_idx_t'(h)) & tl_dev_i.a_ready & a_allow;
         tl_h_o[h].d_valid = tl_dev_i.d_valid & id_nonempty & rst_ni &
                             (id_head == sram_host_idx_t'(h));
      end
   end

   // Priority rotation on each accepted request, and grant lock while stalled.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         prio_q  <= 1'b0;
         lock_q  <= 1'b0;
         grant_q <= 1'b0;
      end else if (a_ack) begin
         prio_q <= ~grant;
         lock_q <= 1'b0;
      end else if (LockOnStall && dev_a_valid && !tl_dev_i.a_ready) begin
         lock_q  <= 1'b1;
         grant_q <= grant;
      end
   end

   prim_fifo_sync #(
      .Width (1),
      .Depth (Outstanding),
      .Pass  (1'b0)
   ) u_id_fifo (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .wvalid_i (a_ack),
      .wdata_i  (grant),
      .rvalid_o (id_nonempty),
      .rready_i (d_ack),
      .rdata_o  (id_head),
      .depth_o  (id_depth)
   );

endmodule

// File: tb/tb_tlul_sram_arb.sv
// Bench for tlul_sram_arb: directed scenarios with literal expectations plus
// a transaction-level model compared against the outputs every cycle.
module tb_tlul_sram_arb;
   import tlul_pkg::*;

   localparam int OUTST = 2;
   localparam logic [7:0] SRC0 = 8'h10;
   localparam logic [7:0] SRC1 = 8'h11;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tl_h2d_t    h_in  [NumSramHosts];
   tl_d2h_t    h_out [NumSramHosts];
   logic [1:0] err;
   tl_h2d_t    dev_out;
   tl_d2h_t    dev_in;
   logic       error_o;

   tlul_sram_arb #(.Outstanding(OUTST), .LockOnStall(1'b1)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .tl_h_i    (h_in),
      .tl_h_o    (h_out),
      .error_h_i (err),
      .tl_dev_o  (dev_out),
      .tl_dev_i  (dev_in),
      .error_o   (error_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- model ----------------
   // Outstanding owners in issue order; head owns the next D beat.
   logic [0:0] exp_q[$];
   int m_prio = 0;
   bit m_lock = 1'b0;
   int m_lock_host = 0;
   bit c_a_ack = 1'b0, c_d_ack = 1'b0, c_stall = 1'b0;
   int c_grant = 0;

   function automatic int model_grant();
      if (m_lock) return m_lock_host;
      if (h_in[0].a_valid && h_in[1].a_valid) return m_prio;
      if (h_in[1].a_valid) return 1;
      return 0;
   endfunction

   // Compare every cycle on the falling edge, away from the active edge.
   always @(negedge clk) begin : cmp
      int  g, head;
      bit  full, ev, er;
      g    = model_grant();
      full = (exp_q.size() == OUTST);
      head = (exp_q.size() > 0) ? int'(exp_q[0]) : -1;
      if (!rst_n) begin
         check("m_rst_a_valid", dev_out.a_valid, 0);
         check("m_rst_d_ready", dev_out.d_ready, 0);
         check("m_rst_error", error_o, 0);
         for (int h = 0; h < NumSramHosts; h++) begin
            check($sformatf("m_rst_a_ready%0d", h), h_out[h].a_ready, 0);
            check($sformatf("m_rst_d_valid%0d", h), h_out[h].d_valid, 0);
         end
         c_a_ack = 1'b0;
         c_d_ack = 1'b0;
         c_stall = 1'b0;
      end else begin
         ev = h_in[g].a_valid && !full;
         check("m_a_valid", dev_out.a_valid, ev);
         if (ev) begin
            check("m_a_source", dev_out.a_source, h_in[g].a_source);
            check("m_a_address", dev_out.a_address, h_in[g].a_address);
            check("m_a_user", dev_out.a_user, h_in[g].a_user);
         end
         check("m_error", error_o, err[g] && h_in[g].a_valid);
         er = (head >= 0) ? h_in[head].d_ready : 1'b0;
         check("m_d_ready", dev_out.d_ready, er);
         for (int h = 0; h < NumSramHosts; h++) begin
            check($sformatf("m_a_ready%0d", h), h_out[h].a_ready,
                  (h == g) && dev_in.a_ready && !full);
            check($sformatf("m_d_valid%0d", h), h_out[h].d_valid,
                  dev_in.d_valid && (h == head));
            if (dev_in.d_valid && h == head)
               check($sformatf("m_d_data%0d", h), h_out[h].d_data, dev_in.d_data);
         end
         c_a_ack = ev && dev_in.a_ready;
         c_d_ack = dev_in.d_valid && er;
         c_stall = ev && !dev_in.a_ready;
         c_grant = g;
      end
   end

   // Advance the model on the active edge using the cycle's observed handshakes.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_prio = 0;
         m_lock = 1'b0;
         exp_q.delete();
      end else begin
         if (c_d_ack) void'(exp_q.pop_front());
         if (c_a_ack) begin
            exp_q.push_back(c_grant[0]);
            m_prio = 1 - c_grant;
            m_lock = 1'b0;
         end else if (c_stall) begin
            m_lock = 1'b1;
            m_lock_host = c_grant;
         end
      end
   end

   // ---------------- driver tasks ----------------
   int beat = 0;

   function automatic tl_h2d_t mk_req(input int h);
      tl_h2d_t r;
      r           = '0;
      r.a_opcode  = Get;
      r.a_size    = 2'd2;
      r.a_source  = SRC0 + 8'(h);
      r.a_address = 32'h1000 * 32'(h + 1);
      r.a_mask    = 4'hF;
      r.a_user    = 16'hA000 + 16'(h);
      return r;
   endfunction

   task automatic drive(input bit v0, input bit v1, input bit ar, input bit dv,
                        input bit dr0, input bit dr1, input logic [1:0] e);
      h_in[0].a_valid = v0;
      h_in[1].a_valid = v1;
      h_in[0].d_ready = dr0;
      h_in[1].d_ready = dr1;
      dev_in.a_ready  = ar;
      dev_in.d_valid  = dv;
      dev_in.d_data   = 32'hD000_0000 + 32'(beat);
      err             = e;
      beat++;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      drive(0, 0, 0, 1, 1, 1, 2'b00);
      cyc();
      cyc();
      drive(0, 0, 0, 0, 0, 0, 2'b00);
      cyc();
   endtask

   // ---------------- directed scenarios ----------------
   logic [7:0] rr_exp [4];

   initial begin
      rr_exp   = '{SRC0, SRC1, SRC0, SRC1};
      h_in[0]  = mk_req(0);
      h_in[1]  = mk_req(1);
      dev_in   = '0;
      dev_in.d_source = 8'h55;

      // Reset with everything asserted: outputs must stay quiet.
      drive(1, 1, 1, 1, 1, 1, 2'b11);
      settle();
      check("rst_a_valid", dev_out.a_valid, 0);
      check("rst_a_ready0", h_out[0].a_ready, 0);
      check("rst_d_valid1", h_out[1].d_valid, 0);
      check("rst_error", error_o, 0);
      cyc();
      cyc();
      rst_n = 1'b1;

      // Round-robin: grants 0,1,0,1 while D drains each beat.
      drive(1, 1, 1, 1, 1, 1, 2'b00);
      for (int i = 0; i < 4; i++) begin
         settle();
         check($sformatf("rr_grant%0d", i), dev_out.a_source, rr_exp[i]);
         check($sformatf("rr_valid%0d", i), dev_out.a_valid, 1);
         cyc();
      end
      drain();

      // Stall lock on host0 with host1 waiting.
      drive(1, 1, 0, 0, 0, 0, 2'b00);
      for (int i = 0; i < 2; i++) begin
         settle();
         check($sformatf("stall_src%0d", i), dev_out.a_source, SRC0);
         check($sformatf("stall_h1_ready%0d", i), h_out[1].a_ready, 0);
         cyc();
      end
      drive(0, 1, 0, 0, 0, 0, 2'b00);
      settle();
      check("stall_locked_valid", dev_out.a_valid, 0);
      check("stall_locked_h1_ready", h_out[1].a_ready, 0);
      cyc();
      drive(1, 1, 1, 0, 0, 0, 2'b00);
      settle();
      check("stall_ack_src", dev_out.a_source, SRC0);
      check("stall_ack_h0_ready", h_out[0].a_ready, 1);
      cyc();
      settle();
      check("post_stall_src", dev_out.a_source, SRC1);
      check("post_stall_h1_ready", h_out[1].a_ready, 1);
      cyc();
      drain();

      // Response routing: host0 then host1 outstanding.
      drive(1, 0, 1, 0, 0, 0, 2'b00);
      cyc();
      drive(0, 1, 1, 0, 0, 0, 2'b00);
      cyc();
      drive(0, 0, 0, 1, 0, 1, 2'b00);
      settle();
      check("route_wait_h0_dvalid", h_out[0].d_valid, 1);
      check("route_wait_h1_dvalid", h_out[1].d_valid, 0);
      check("route_wait_d_ready", dev_out.d_ready, 0);
      cyc();
      drive(0, 0, 0, 1, 1, 0, 2'b00);
      settle();
      check("route_b0_h0_dvalid", h_out[0].d_valid, 1);
      check("route_b0_d_ready", dev_out.d_ready, 1);
      cyc();
      drive(0, 0, 0, 1, 0, 1, 2'b00);
      settle();
      check("route_b1_h0_dvalid", h_out[0].d_valid, 0);
      check("route_b1_h1_dvalid", h_out[1].d_valid, 1);
      check("route_b1_d_ready", dev_out.d_ready, 1);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 2'b00);
      cyc();

      // Full: two outstanding, third accepted only after a d_ack.
      drive(1, 0, 1, 0, 0, 0, 2'b00);
      cyc();
      cyc();
      drive(1, 1, 1, 0, 0, 0, 2'b00);
      settle();
      check("full_h0_ready", h_out[0].a_ready, 0);
      check("full_h1_ready", h_out[1].a_ready, 0);
      check("full_a_valid", dev_out.a_valid, 0);
      cyc();
      drive(1, 1, 1, 1, 1, 0, 2'b00);
      settle();
      check("full_pop_h1_ready", h_out[1].a_ready, 0);
      check("full_pop_d_ready", dev_out.d_ready, 1);
      cyc();
      drive(1, 1, 1, 0, 0, 0, 2'b00);
      settle();
      check("after_pop_h1_ready", h_out[1].a_ready, 1);
      check("after_pop_src", dev_out.a_source, SRC1);
      cyc();
      drain();

      // Error feed follows the granted host only.
      drive(0, 1, 1, 0, 0, 0, 2'b10);
      settle();
      check("err_h1_granted", error_o, 1);
      check("err_h1_passthru", dev_out.a_valid, 1);
      cyc();
      drive(1, 0, 1, 0, 0, 0, 2'b10);
      settle();
      check("err_h0_granted", error_o, 0);
      cyc();
      drive(1, 0, 1, 0, 0, 0, 2'b01);
      settle();
      check("err_h0_own", error_o, 1);
      cyc();
      drain();

      // Reset with one request outstanding.
      drive(1, 0, 1, 0, 0, 0, 2'b00);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 2'b00);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      drive(1, 1, 1, 1, 1, 1, 2'b00);
      settle();
      check("rstmid_h0_dvalid", h_out[0].d_valid, 0);
      check("rstmid_h1_dvalid", h_out[1].d_valid, 0);
      check("rstmid_d_ready", dev_out.d_ready, 0);
      check("rstmid_prio_src", dev_out.a_source, SRC0);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 2'b00);
      cyc();
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
